// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: program loader that turns symbolic instruction requests
// into 32-bit MIPS words and writes them sequentially into instruction memory.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, finish     load control pulses (start honoured in IDLE/DONE, finish in RUN)
//   req_*             request handshake and instruction fields (kind, rs, rt, rd, imm, target)
//   imem_*            instruction-memory write port (we/addr/wdata, ready from memory)
//   busy, done        load status (busy in RUN/DRAIN/HALT, done level in DONE)
//   word_count        words written since the last start (saturating)
//   illegal           one-cycle pulse after an accepted illegal kind
//   addr_wrap         sticky flag set when the write address wraps, cleared by start
//
// Optional feature macro: HALT_APPEND_EN. When defined, a self-loop jump
// {0x02, imem_addr} is appended after the drained program before DONE.
module mips_instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              illegal,
  output logic              addr_wrap
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

`ifdef HALT_APPEND_EN
  typedef enum logic [2:0] {StIdle, StRun, StDrain, StHalt, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StRun, StDrain, StDone} state_e;
`endif

  state_e              state_q;
  logic [31:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     word_count_q;
  logic                addr_wrap_q;
  logic                illegal_q;

  logic        full, empty, accept, legal, push, pop, wr_hs, in_halt;
  logic [31:0] enc_word;

  // Instruction encoder
  always_comb begin
    legal    = 1'b1;
    enc_word = 32'h0;
    case (req_kind)
      4'd0:    enc_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h20}; // ADD
      4'd1:    enc_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h22}; // SUB
      4'd2:    enc_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h2A}; // SLT
      4'd3:    enc_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h1C}; // MUL
      4'd4:    enc_word = {6'h08, req_rs, req_rt, req_imm};             // ADDI
      4'd5:    enc_word = {6'h23, req_rs, req_rt, req_imm};             // LW
      4'd6:    enc_word = {6'h2B, req_rs, req_rt, req_imm};             // SW
      4'd7:    enc_word = {6'h04, req_rs, req_rt, req_imm};             // BEQ
      4'd8:    enc_word = {6'h02, req_target};                          // J
      default: legal    = 1'b0;
    endcase
  end

  always_comb begin
    full      = (count_q == FULL_CNT);
    empty     = (count_q == '0);
`ifdef HALT_APPEND_EN
    in_halt   = (state_q == StHalt);
`else
    in_halt   = 1'b0;
`endif
    // Full is checked against the registered count, so a same-cycle pop never frees a slot.
    req_ready = (state_q == StRun) && !full;
    accept    = req_valid && req_ready;
    push      = accept && legal;
    imem_we   = (((state_q == StRun) || (state_q == StDrain)) && !empty) || in_halt;
    imem_wdata = in_halt ? {6'h02, 26'(addr_q)} : mem_q[rd_ptr_q];
    wr_hs     = imem_we && imem_ready;
    pop       = wr_hs && !in_halt;
    imem_addr  = addr_q;
    word_count = word_count_q;
    addr_wrap  = addr_wrap_q;
    illegal    = illegal_q;
    done       = (state_q == StDone);
    busy       = (state_q == StRun) || (state_q == StDrain) || in_halt;
  end

  // FIFO storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= enc_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      addr_q       <= BASE;
      word_count_q <= '0;
      addr_wrap_q  <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      illegal_q <= accept && !legal;

      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase

      if (wr_hs) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (addr_q == ADDR_MAX) addr_wrap_q <= 1'b1;
        if (!(&word_count_q)) word_count_q <= word_count_q + (ADDR_W + 1)'(1);
      end

      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q      <= StRun;
            addr_q       <= BASE;
            word_count_q <= '0;
            addr_wrap_q  <= 1'b0;
          end
        end
        StRun: begin
          if (finish) state_q <= StDrain;
        end
        StDrain: begin
          // An empty FIFO also means no write is pending.
          if (empty) begin
`ifdef HALT_APPEND_EN
            state_q <= StHalt;
`else
            state_q <= StDone;
`endif
          end
        end
`ifdef HALT_APPEND_EN
        StHalt: begin
          if (wr_hs) state_q <= StDone;
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Program loader that assembles symbolic instruction requests into 32-bit MIPS words and writes them sequentially into instruction memory.
- Produces exactly the opcode/funct encodings the control-unit decoder consumes: R-type ADD/SUB/SLT/MUL, and ADDI, LW, SW, BEQ, J.
- Sits between a testbench or boot source and the instruction memory write port.
- Contains a small FIFO to decouple request acceptance from memory write stalls.

Parameters:
- DEPTH, 4: encoded-word FIFO depth. Power of two, at least 2.
- ADDR_W, 8: instruction-memory word address width.
- BASE_ADDR, 0: first write address after each start.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  pulse; begins a program load
- finish  input  1  pulse; ends a program load (drain, then done)
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid && req_ready at clk edge
- req_kind  input  4  0 ADD, 1 SUB, 2 SLT, 3 MUL, 4 ADDI, 5 LW, 6 SW, 7 BEQ, 8 J; 9-15 illegal
- req_rs  input  5  source register rs
- req_rt  input  5  source/target register rt
- req_rd  input  5  destination register rd (R-type only)
- req_imm  input  16  immediate (I-type)
- req_target  input  26  jump target (J)
- imem_we  output  1  write strobe
- imem_addr  output  ADDR_W  word address
- imem_wdata  output  32  encoded instruction
- imem_ready  input  1  memory accepts write when imem_we && imem_ready
- busy  output  1  state is RUN, DRAIN or HALT
- done  output  1  level; high in DONE
- word_count  output  ADDR_W+1  words written since last start
- illegal  output  1  one-cycle pulse on each accepted illegal kind
- addr_wrap  output  1  sticky; set when imem_addr wraps; cleared by start

Behaviour:
- Reset values: state IDLE, imem_addr=BASE_ADDR, FIFO empty, all other outputs 0.
- Encoding, field layout op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0]:
  - R-type: op 0, shamt 0. funct ADD 0x20, SUB 0x22, SLT 0x2A, MUL 0x1C.
  - I-type: {op, rs, rt, imm} with op ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04.
  - J: {0x02, target}.
- Illegal kind: accepted, not pushed to the FIFO, illegal pulses the next cycle, no count change.
- State IDLE: req_ready=0, imem_we=0. On start, go to RUN and set imem_addr=BASE_ADDR, word_count=0, addr_wrap=0.
- State RUN:
  - req_ready = !full. A request is never accepted while the FIFO is full, even if a pop occurs in the same cycle.
  - An accepted word enters the FIFO at the edge. imem_we goes high from the next cycle, so the minimum latency is 1 cycle.
  - finish moves the state to DRAIN. A request in the same cycle as finish is still accepted.
  - start is ignored.
- State DRAIN: req_ready=0. Once the FIFO is empty and no write is pending, go to DONE (or HALT with the optional feature).
- State DONE: done=1, busy=0. start re-enters RUN with the same initialisation as from IDLE.
- Write side:
  - imem_we = (FIFO non-empty) in RUN or DRAIN.
  - imem_wdata is the FIFO head. imem_addr and imem_wdata are held stable while imem_we && !imem_ready.
  - On a write handshake: pop, imem_addr+1, word_count+1.
  - Wrap: when a write occurs at imem_addr = 2^ADDR_W-1, the next address is 0, addr_wrap is set, and the load continues.
  - word_count saturates at its maximum.
- start and finish in IDLE/DONE: only start is honoured. In RUN: only finish is honoured.
- Asynchronous reset mid-load: FIFO flushed, return to IDLE at once, imem_we drops immediately.

Optional Feature:
- Macro: HALT_APPEND_EN.
- Defined: after DRAIN empties, enter state HALT for exactly one write of {0x02, zero-extended imem_addr}, a self-loop jump that parks the core. The write respects imem_ready, increments word_count, then the state moves to DONE.
- Undefined: no HALT state; DRAIN goes directly to DONE.

Test Plan:
- Basic R-type load: reset, start, then ADD rs=1 rt=2 rd=3 -> imem_wdata 0x00221820 at addr 0. MUL with the same fields -> 0x0022181C at addr 1. After finish: done=1, word_count=2.
- I-type and J encodings: LW rs=29 rt=8 imm=0x0004 -> 0x8FA80004. SW imm=0x0008 -> 0xAFA80008. BEQ rs=4 rt=5 imm=0xFFFE -> 0x1085FFFE. J target=0x10 -> 0x08000010.
- Backpressure: hold imem_ready=0 and push 5 requests with DEPTH=4 -> req_ready low after the 4th, address and data held stable. Release -> 4 sequential writes with no loss or duplication.
- Illegal kind: req_kind=12 -> illegal pulses once, no write occurs, word_count unchanged, next legal word goes to the expected next address.
- Address wrap: ADDR_W=2, BASE_ADDR=3, load 2 words -> addresses 3 then 0, addr_wrap=1. A following start clears addr_wrap.
- Reset mid-load and HALT: assert rst with 2 words queued -> imem_we=0 immediately, state IDLE. With HALT_APPEND_EN, load 1 word at addr 0 -> second write 0x08000001 at addr 1, word_count=2.
